inp_prefetch: RTL and testbench

Requester and buffer between input_unit and the CU. It acts as the master of the 4-phase inp_req/inp_ack handshake and pushes each captured inp_data word into a small show-ahead FIFO. The CU pops words through a valid/ready interface. With prefetch enabled, input is read ahead so IN instructions do not stall on the handshake.

---
 rtl/inp_prefetch.sv | 128 ++++++++++++
 tb/tb_inp_prefetch.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inp_prefetch.sv
// Input prefetcher: masters the 4-phase inp_req/inp_ack handshake with
// input_unit and buffers captured words in a show-ahead FIFO for the CU.
module inp_prefetch #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pf_en,
  input  logic          flush,
  output logic          inp_req,
  input  logic [DW-1:0] inp_data,
  input  logic          inp_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            discard_q, discard_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            start;
  logic            ack_in_req;
  logic            push;
  logic            pop;

  // Only one handshake is ever outstanding, so checking count here is
  // enough to guarantee the eventual push finds a free slot.
  always_comb begin
    if (pf_en) start = (count_q < CW'(DEPTH));
    else       start = (count_q == '0) && rd_ready;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d    = state_q;
    req_d      = req_q;
    discard_d  = discard_q;
    ack_in_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Waiting for inp_ack=0 keeps a stale ack from being taken as a new one.
        if (!inp_ack && start) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (flush) discard_d = 1'b1;
        if (inp_ack) begin
          ack_in_req = 1'b1;
          req_d      = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!inp_ack) begin
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      discard_q <= discard_d;
    end
  end

  assign push = ack_in_req && !discard_q && !flush;
  assign pop  = rd_valid && rd_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates rd_data, so stale
  // entries are never visible and the array can map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= inp_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign inp_req  = req_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_inp_prefetch.sv
// Self-checking bench for inp_prefetch: randomized input_unit responder plus a
// queue-based reference of the words the CU should see, checked every cycle.
module tb_inp_prefetch;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, pf_en, flush, rd_ready;
  logic          inp_req, rd_valid, busy;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;
  wire           inp_ack;
  wire  [DW-1:0] inp_data;

  // input_unit is either the automatic responder or driven by hand from a test.
  logic          auto_resp, a_ack, man_ack;
  logic [DW-1:0] a_data, man_data;
  assign inp_ack  = auto_resp ? a_ack  : man_ack;
  assign inp_data = auto_resp ? a_data : man_data;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  bit mon_en = 0;
  int extra_hold = 0;
  int max_dly = 2;

  logic [DW-1:0] model_q[$];
  bit            model_disc;

  logic [DW-1:0] resp_mem [32];
  int            resp_wr = 0;
  int            resp_rd = 0;

  always #5 clk = ~clk;

  inp_prefetch #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pf_en    (pf_en),
    .flush    (flush),
    .inp_req  (inp_req),
    .inp_data (inp_data),
    .inp_ack  (inp_ack),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .count    (count),
    .busy     (busy)
  );

  // Reference: the words handed over by completed handshakes, in order.
  task automatic run_model();
    bit do_pop;
    forever begin
      @(posedge clk);
      if (rst) begin
        model_q.delete();
        model_disc = 0;
      end else begin
        do_pop = (model_q.size() != 0) && rd_ready && !flush;
        if (do_pop) void'(model_q.pop_front());
        if (inp_req && inp_ack) begin
          hs_cnt++;
          if (!model_disc && !flush) model_q.push_back(inp_data);
          model_disc = 0;
        end else if (inp_req && flush) begin
          model_disc = 1;
        end
        if (flush) model_q.delete();
      end
    end
  endtask

  task automatic queue_word(input logic [DW-1:0] w);
    resp_mem[resp_wr % 32] = w;
    resp_wr++;
  endtask

  task automatic run_responder();
    int r_st, dly, hold;
    r_st = 0; dly = 0; hold = 0;
    a_ack = 1'b0; a_data = '0;
    forever begin
      @(negedge clk);
      if (!auto_resp) begin
        r_st = 0;
        a_ack = 1'b0;
      end else begin
        case (r_st)
          0: if (inp_req) begin
               dly = $urandom_range(0, max_dly);
               r_st = 1;
             end
          2: if (!inp_req) begin
               hold = extra_hold;
               r_st = 3;
             end
          default: ;
        endcase
        if (r_st == 1) begin
          if (dly == 0) begin
            a_ack = 1'b1;
            if (resp_rd != resp_wr) begin
              a_data = resp_mem[resp_rd % 32];
              resp_rd++;
            end else begin
              a_data = DW'($urandom);
            end
            r_st = 2;
          end else begin
            dly--;
          end
        end
        if (r_st == 3) begin
          if (hold == 0) begin
            a_ack = 1'b0;
            r_st = 0;
          end else begin
            hold--;
          end
        end
      end
    end
  endtask

  task automatic run_checker();
    logic          prev_req, prev_ack;
    logic [DW-1:0] exp_d;
    prev_req = 1'b0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !rst) begin
        exp_d = (model_q.size() != 0) ? model_q[0] : '0;
        n_vec++;
        if (count !== CW'(model_q.size()) || rd_valid !== (model_q.size() != 0) || rd_data !== exp_d) begin
          n_err++;
          $display("FAIL scoreboard @%0t: count=%0d valid=%b data=%h, expected count=%0d valid=%b data=%h",
                   $time, count, rd_valid, rd_data, model_q.size(), model_q.size() != 0, exp_d);
        end
        n_vec++;
        if (inp_req && count >= CW'(DEPTH)) begin
          n_err++;
          $display("FAIL req_when_full @%0t: inp_req=1 with count=%0d, expected count<%0d", $time, count, DEPTH);
        end
        n_vec++;
        if (inp_req && !prev_req && prev_ack) begin
          n_err++;
          $display("FAIL req_on_stale_ack @%0t: inp_req rose while inp_ack=1, expected inp_req=0", $time);
        end
      end
      prev_req = inp_req;
      prev_ack = inp_ack;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pf_en = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    auto_resp = 1'b0; man_ack = 1'b0; man_data = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (inp_req  !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", inp_req); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    n_vec++; if (rd_data  !== '0)   begin n_err++; $display("FAIL reset_data: got %h expected 0", rd_data); end
    n_vec++; if (count    !== '0)   begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_vec++; if (busy     !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    mon_en = 1;
  endtask

  task automatic test_prefetch_fill();
    int t, hs0;
    bit seen;
    for (int i = 0; i < 5; i++) queue_word(DW'(5 + i));
    hs0 = hs_cnt;
    extra_hold = 0; max_dly = 2; auto_resp = 1'b1;
    pf_en = 1'b1; rd_ready = 1'b0;
    t = 0;
    while (!(count == CW'(DEPTH) && !busy) && t < 200) begin @(negedge clk); t++; end
    n_vec++; if (!(count == CW'(DEPTH) && !busy)) begin n_err++; $display("FAIL fill_timeout: count=%0d busy=%b expected %0d/0", count, busy, DEPTH); end
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= inp_req; end
    n_vec++; if (seen)              begin n_err++; $display("FAIL fill_req_while_full: got inp_req=1 expected 0"); end
    n_vec++; if (hs_cnt - hs0 != 4) begin n_err++; $display("FAIL fill_handshakes: got %0d expected 4", hs_cnt - hs0); end
    n_vec++; if (count !== 3'd4)    begin n_err++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_vec++; if (rd_data !== 16'd5) begin n_err++; $display("FAIL fill_head: got %h expected 5", rd_data); end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    t = 0;
    while (!(count == CW'(DEPTH) && !busy) && t < 100) begin @(negedge clk); t++; end
    n_vec++; if (hs_cnt - hs0 != 5) begin n_err++; $display("FAIL fifth_handshake: got %0d expected 5", hs_cnt - hs0); end
    n_vec++; if (rd_data !== 16'd6) begin n_err++; $display("FAIL refill_head: got %h expected 6", rd_data); end
    pf_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_ready = 1'b1;
      n_vec++; if (rd_data !== DW'(6 + i)) begin n_err++; $display("FAIL fill_order[%0d]: got %h expected %h", i, rd_data, 6 + i); end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL fill_drain: got %0d expected 0", count); end
  endtask

  task automatic test_demand();
    int t, hs0;
    bit seen;
    pf_en = 1'b0; rd_ready = 1'b0;
    hs0 = hs_cnt;
    queue_word(16'h1234);
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= inp_req; end
    n_vec++; if (seen) begin n_err++; $display("FAIL demand_idle_req: got inp_req=1 expected 0"); end
    rd_ready = 1'b1;
    t = 0;
    while (!rd_valid && t < 50) begin @(negedge clk); t++; end
    n_vec++; if (rd_valid !== 1'b1)     begin n_err++; $display("FAIL demand_timeout: rd_valid=%b expected 1", rd_valid); end
    n_vec++; if (rd_data !== 16'h1234)  begin n_err++; $display("FAIL demand_data: got %h expected 1234", rd_data); end
    @(negedge clk);
    rd_ready = 1'b0;
    n_vec++; if (count !== '0)          begin n_err++; $display("FAIL demand_popped: count=%0d expected 0", count); end
    repeat (5) @(negedge clk);
    n_vec++; if (hs_cnt - hs0 != 1)     begin n_err++; $display("FAIL demand_handshakes: got %0d expected 1", hs_cnt - hs0); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL demand_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_wrap();
    int t;
    logic [DW-1:0] s[$];
    logic [DW-1:0] got[3];
    for (int r = 0; r < 2; r++) begin
      pf_en = 1'b1; rd_ready = 1'b0;
      t = 0;
      while (!(count == CW'(DEPTH) && !busy) && t < 200) begin @(negedge clk); t++; end
      n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL wrap_fill[%0d]: got %0d expected 4", r, count); end
      pf_en = 1'b0;
      repeat (4) begin rd_ready = 1'b1; @(negedge clk); end
      rd_ready = 1'b0;
    end
    pf_en = 1'b1;
    t = 0;
    while (!(count == CW'(DEPTH) && !busy) && t < 200) begin @(negedge clk); t++; end
    s = model_q;
    auto_resp = 1'b0; man_ack = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    t = 0;
    while (!inp_req && t < 10) begin @(negedge clk); t++; end
    n_vec++; if (inp_req !== 1'b1) begin n_err++; $display("FAIL simul_req: got %b expected 1", inp_req); end
    man_ack = 1'b1; man_data = 16'hBEEF; rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0; pf_en = 1'b0; man_ack = 1'b0;
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL simul_count: got %0d expected 3", count); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rd_ready = 1'b1;
      got[i] = rd_data;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    n_vec++; if (got[0] !== s[2] || got[1] !== s[3]) begin n_err++; $display("FAIL simul_order: got %h %h expected %h %h", got[0], got[1], s[2], s[3]); end
    n_vec++; if (got[2] !== 16'hBEEF) begin n_err++; $display("FAIL simul_last: got %h expected beef", got[2]); end
    n_vec++; if (count !== '0)        begin n_err++; $display("FAIL simul_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush_req();
    int t;
    bit seen;
    auto_resp = 1'b0; man_ack = 1'b0; pf_en = 1'b1; rd_ready = 1'b0;
    t = 0;
    while (!inp_req && t < 10) begin @(negedge clk); t++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++; if (inp_req !== 1'b1) begin n_err++; $display("FAIL flush_req_held: got %b expected 1", inp_req); end
    man_ack = 1'b1; man_data = 16'h00AA;
    @(negedge clk);
    n_vec++; if (inp_req !== 1'b0) begin n_err++; $display("FAIL flush_req_drop: got %b expected 0", inp_req); end
    man_ack = 1'b0;
    seen = rd_valid;
    t = 0;
    while (!inp_req && t < 10) begin @(negedge clk); seen |= rd_valid; t++; end
    n_vec++; if (seen)           begin n_err++; $display("FAIL flush_discard: rd_valid rose for 00aa, expected 0"); end
    n_vec++; if (inp_req !== 1'b1) begin n_err++; $display("FAIL flush_rereq: got %b expected 1", inp_req); end
    pf_en = 1'b0; man_ack = 1'b1; man_data = 16'h00BB;
    @(negedge clk);
    man_ack = 1'b0;
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'h00BB) begin n_err++; $display("FAIL flush_next: got valid=%b data=%h expected 1/00bb", rd_valid, rd_data); end
    @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    bit seen;
    auto_resp = 1'b0; man_ack = 1'b0; pf_en = 1'b1; rd_ready = 1'b0;
    t = 0;
    while (!inp_req && t < 10) begin @(negedge clk); t++; end
    man_ack = 1'b1; man_data = 16'h5555; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (inp_req  !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %b expected 0", inp_req); end
    n_vec++; if (count    !== '0)   begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== '0) begin n_err++; $display("FAIL rstmid_rd: got %b/%h expected 0/0", rd_valid, rd_data); end
    n_vec++; if (busy     !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= inp_req; end
    n_vec++; if (seen) begin n_err++; $display("FAIL rstmid_stale_ack: got inp_req=1 expected 0"); end
    man_ack = 1'b0;
    t = 0;
    while (!inp_req && t < 5) begin @(negedge clk); t++; end
    n_vec++; if (inp_req !== 1'b1) begin n_err++; $display("FAIL rstmid_rereq: got %b expected 1", inp_req); end
    pf_en = 1'b0; man_ack = 1'b1; man_data = 16'h7777;
    @(negedge clk);
    man_ack = 1'b0;
    n_vec++; if (rd_data !== 16'h7777) begin n_err++; $display("FAIL rstmid_data: got %h expected 7777", rd_data); end
    @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_ack_hold();
    int t, hs0;
    logic [DW-1:0] w[4];
    for (int i = 0; i < 4; i++) begin w[i] = DW'($urandom); queue_word(w[i]); end
    hs0 = hs_cnt;
    extra_hold = 2; max_dly = 1; auto_resp = 1'b1;
    pf_en = 1'b1; rd_ready = 1'b0;
    t = 0;
    while (!(count == CW'(DEPTH) && !busy) && t < 200) begin @(negedge clk); t++; end
    n_vec++; if (hs_cnt - hs0 != 4) begin n_err++; $display("FAIL hold_handshakes: got %0d expected 4", hs_cnt - hs0); end
    n_vec++; if (count !== 3'd4)    begin n_err++; $display("FAIL hold_count: got %0d expected 4", count); end
    pf_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_ready = 1'b1;
      n_vec++; if (rd_data !== w[i]) begin n_err++; $display("FAIL hold_order[%0d]: got %h expected %h", i, rd_data, w[i]); end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    extra_hold = 0;
  endtask

  task automatic test_random();
    int t;
    auto_resp = 1'b1; max_dly = 3;
    repeat (600) begin
      @(negedge clk);
      pf_en    = ($urandom_range(0, 3) != 0);
      rd_ready = $urandom_range(0, 1) != 0;
      flush    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) extra_hold = $urandom_range(0, 2);
    end
    @(negedge clk);
    pf_en = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    t = 0;
    while (busy && t < 60) begin @(negedge clk); t++; end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL random_settle: busy=%b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; pf_en = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    auto_resp = 1'b0; man_ack = 1'b0; man_data = '0;
    fork
      run_model();
      run_responder();
      run_checker();
    join_none
    test_reset();
    test_prefetch_fill();
    test_demand();
    test_full_wrap();
    test_flush_req();
    test_reset_mid();
    test_ack_hold();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
